// File: rtl/udp_fragment_slot_manager.sv
// rtl/udp_fragment_slot_manager.sv - UDP fragment reassembly slot lifecycle, timeout and drain arbitration
module udp_fragment_slot_manager #(
  parameter int          FRAGMENT_SLOTS   = 2,
  parameter logic [15:0] TIMEOUT_CYCLES   = 16'd1000,
  parameter logic [15:0] MAX_PACKET_BYTES = 16'd1500,
  localparam int         SLOT_W           = $clog2(FRAGMENT_SLOTS)
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [FRAGMENT_SLOTS-1:0]    push_data_valid,
  input  logic [FRAGMENT_SLOTS-1:0]    push_data_last,
  input  logic [15:0]                  packet_id,
  input  logic                         drain_ready,
  input  logic                         drain_done,
  output logic [FRAGMENT_SLOTS-1:0]    fragment_slot_empty,
  output logic [FRAGMENT_SLOTS*16-1:0] fragment_slot_packet_id,
  output logic                         drain_valid,
  output logic [SLOT_W-1:0]            drain_slot,
  output logic [15:0]                  drain_length,
  output logic [FRAGMENT_SLOTS-1:0]    slot_timeout,
  output logic                         protocol_error
);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_FILLING,
    S_COMPLETE,
    S_DRAINING
  } slot_state_t;

  localparam logic [15:0] IDLE_LIMIT = TIMEOUT_CYCLES - 16'd1;

  slot_state_t state_q    [FRAGMENT_SLOTS];
  slot_state_t state_d    [FRAGMENT_SLOTS];
  logic [15:0] pkt_id_q   [FRAGMENT_SLOTS];
  logic [15:0] pkt_id_d   [FRAGMENT_SLOTS];
  logic [15:0] byte_cnt_q [FRAGMENT_SLOTS];
  logic [15:0] byte_cnt_d [FRAGMENT_SLOTS];
  logic [15:0] idle_cnt_q [FRAGMENT_SLOTS];
  logic [15:0] idle_cnt_d [FRAGMENT_SLOTS];

  logic [FRAGMENT_SLOTS-1:0] timeout_d;
  logic                      perr_d;
  logic                      drain_accept;
  logic                      any_draining;
  logic                      grant_found;
  logic [SLOT_W-1:0]         grant_idx;
  logic [SLOT_W-1:0]         rr_ptr_q;
  logic [SLOT_W-1:0]         rr_next;

  assign drain_accept = drain_valid && drain_ready;

  always_comb begin : slot_next
    perr_d    = 1'b0;
    timeout_d = '0;
    for (int i = 0; i < FRAGMENT_SLOTS; i++) begin
      state_d[i]    = state_q[i];
      pkt_id_d[i]   = pkt_id_q[i];
      byte_cnt_d[i] = byte_cnt_q[i];
      idle_cnt_d[i] = idle_cnt_q[i];
      case (state_q[i])
        S_EMPTY: begin
          if (push_data_valid[i]) begin
            // A same-cycle last closes a one-byte packet immediately.
            state_d[i]    = push_data_last[i] ? S_COMPLETE : S_FILLING;
            pkt_id_d[i]   = packet_id;
            byte_cnt_d[i] = 16'd1;
            idle_cnt_d[i] = 16'd0;
          end else if (push_data_last[i]) begin
            perr_d = 1'b1;
          end
        end
        S_FILLING: begin
          if (push_data_valid[i]) begin
            if (byte_cnt_q[i] >= MAX_PACKET_BYTES) begin
              state_d[i]    = S_EMPTY;
              pkt_id_d[i]   = 16'd0;
              byte_cnt_d[i] = 16'd0;
              idle_cnt_d[i] = 16'd0;
              timeout_d[i]  = 1'b1;
            end else begin
              byte_cnt_d[i] = byte_cnt_q[i] + 16'd1;
              idle_cnt_d[i] = 16'd0;
              if (push_data_last[i]) state_d[i] = S_COMPLETE;
            end
          end else if (push_data_last[i]) begin
            state_d[i] = S_COMPLETE;
          end else if (idle_cnt_q[i] == IDLE_LIMIT) begin
            state_d[i]    = S_EMPTY;
            pkt_id_d[i]   = 16'd0;
            byte_cnt_d[i] = 16'd0;
            idle_cnt_d[i] = 16'd0;
            timeout_d[i]  = 1'b1;
          end else if (idle_cnt_q[i] != 16'hFFFF) begin
            idle_cnt_d[i] = idle_cnt_q[i] + 16'd1;
          end
        end
        S_COMPLETE: begin
          if (push_data_valid[i] || push_data_last[i]) perr_d = 1'b1;
          if (drain_accept && (int'(drain_slot) == i)) state_d[i] = S_DRAINING;
        end
        S_DRAINING: begin
          if (push_data_valid[i] || push_data_last[i]) perr_d = 1'b1;
          if (drain_done) begin
            state_d[i]    = S_EMPTY;
            pkt_id_d[i]   = 16'd0;
            byte_cnt_d[i] = 16'd0;
            idle_cnt_d[i] = 16'd0;
          end
        end
        default: state_d[i] = S_EMPTY;
      endcase
    end
  end

  // Round-robin scan of registered state, starting at the pointer.
  always_comb begin : rr_scan
    grant_found  = 1'b0;
    grant_idx    = '0;
    any_draining = 1'b0;
    for (int k = 0; k < FRAGMENT_SLOTS; k++) begin
      if (state_q[k] == S_DRAINING) any_draining = 1'b1;
      if (!grant_found && state_q[(int'(rr_ptr_q) + k) % FRAGMENT_SLOTS] == S_COMPLETE) begin
        grant_found = 1'b1;
        grant_idx   = SLOT_W'((int'(rr_ptr_q) + k) % FRAGMENT_SLOTS);
      end
    end
  end

  assign rr_next = (int'(grant_idx) == FRAGMENT_SLOTS - 1) ? '0 : grant_idx + 1'b1;

  always_comb begin : id_flatten
    fragment_slot_packet_id = '0;
    for (int i = 0; i < FRAGMENT_SLOTS; i++) begin
      fragment_slot_packet_id[i*16 +: 16] = pkt_id_q[i];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < FRAGMENT_SLOTS; i++) begin
        state_q[i]    <= S_EMPTY;
        pkt_id_q[i]   <= 16'd0;
        byte_cnt_q[i] <= 16'd0;
        idle_cnt_q[i] <= 16'd0;
      end
      fragment_slot_empty <= '1;
      slot_timeout        <= '0;
      protocol_error      <= 1'b0;
      drain_valid         <= 1'b0;
      drain_slot          <= '0;
      drain_length        <= 16'd0;
      rr_ptr_q            <= '0;
    end else begin
      for (int i = 0; i < FRAGMENT_SLOTS; i++) begin
        state_q[i]             <= state_d[i];
        pkt_id_q[i]            <= pkt_id_d[i];
        byte_cnt_q[i]          <= byte_cnt_d[i];
        idle_cnt_q[i]          <= idle_cnt_d[i];
        fragment_slot_empty[i] <= (state_d[i] == S_EMPTY);
      end
      slot_timeout   <= timeout_d;
      protocol_error <= perr_d;
      if (drain_accept) begin
        drain_valid <= 1'b0;
      end else if (!drain_valid && !any_draining && grant_found) begin
        drain_valid  <= 1'b1;
        drain_slot   <= grant_idx;
        drain_length <= byte_cnt_q[grant_idx];
        rr_ptr_q     <= rr_next;
      end
    end
  end

endmodule

// File: tb/tb_udp_fragment_slot_manager.sv
// tb/tb_udp_fragment_slot_manager.sv - directed self-checking bench for udp_fragment_slot_manager
module tb_udp_fragment_slot_manager;

  logic        clock;
  logic        reset_n;
  logic [1:0]  push_data_valid;
  logic [1:0]  push_data_last;
  logic [15:0] packet_id;
  logic        drain_ready;
  logic        drain_done;
  logic [1:0]  fragment_slot_empty;
  logic [31:0] fragment_slot_packet_id;
  logic        drain_valid;
  logic        drain_slot;
  logic [15:0] drain_length;
  logic [1:0]  slot_timeout;
  logic        protocol_error;

  int checks = 0;
  int errors = 0;
  logic seen;

  udp_fragment_slot_manager #(
    .FRAGMENT_SLOTS   (2),
    .TIMEOUT_CYCLES   (16'd8),
    .MAX_PACKET_BYTES (16'd4)
  ) dut (
    .clock                   (clock),
    .reset_n                 (reset_n),
    .push_data_valid         (push_data_valid),
    .push_data_last          (push_data_last),
    .packet_id               (packet_id),
    .drain_ready             (drain_ready),
    .drain_done              (drain_done),
    .fragment_slot_empty     (fragment_slot_empty),
    .fragment_slot_packet_id (fragment_slot_packet_id),
    .drain_valid             (drain_valid),
    .drain_slot              (drain_slot),
    .drain_length            (drain_length),
    .slot_timeout            (slot_timeout),
    .protocol_error          (protocol_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [1:0] v, input logic [1:0] l, input logic rdy, input logic done);
    push_data_valid = v;
    push_data_last  = l;
    drain_ready     = rdy;
    drain_done      = done;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(2'b00, 2'b00, 1'b0, 1'b0);
    step(2'b00, 2'b00, 1'b0, 1'b0);
    reset_n = 1'b1;
  endtask

  initial begin
    packet_id = 16'h0000;
    do_reset();

    // Reset state
    check("rst_empty", 32'(fragment_slot_empty), 32'h3);
    check("rst_dv", 32'(drain_valid), 32'h0);
    check("rst_dslot", 32'(drain_slot), 32'h0);
    check("rst_dlen", 32'(drain_length), 32'h0);
    check("rst_tmo", 32'(slot_timeout), 32'h0);
    check("rst_perr", 32'(protocol_error), 32'h0);
    check("rst_ids", fragment_slot_packet_id, 32'h0);

    // Three bytes into slot 0, then last
    packet_id = 16'hBEEF;
    step(2'b01, 2'b00, 1'b0, 1'b0);
    check("s1_empty_after_push", 32'(fragment_slot_empty), 32'h2);
    check("s1_id0", 32'(fragment_slot_packet_id[15:0]), 32'hBEEF);
    step(2'b01, 2'b00, 1'b0, 1'b0);
    step(2'b01, 2'b00, 1'b0, 1'b0);
    step(2'b00, 2'b01, 1'b0, 1'b0);
    check("s1_dv_not_yet", 32'(drain_valid), 32'h0);
    step(2'b00, 2'b00, 1'b0, 1'b0);
    check("s1_dv", 32'(drain_valid), 32'h1);
    check("s1_dslot", 32'(drain_slot), 32'h0);
    check("s1_dlen", 32'(drain_length), 32'd3);
    step(2'b00, 2'b00, 1'b1, 1'b0);
    check("s1_dv_drop", 32'(drain_valid), 32'h0);
    step(2'b00, 2'b00, 1'b0, 1'b1);
    check("s1_empty_after_done", 32'(fragment_slot_empty), 32'h3);

    // Both slots complete together, ready held high
    do_reset();
    packet_id = 16'h1111;
    step(2'b11, 2'b00, 1'b1, 1'b0);
    step(2'b11, 2'b11, 1'b1, 1'b0);
    step(2'b00, 2'b00, 1'b1, 1'b0);
    check("s2_dv0", 32'(drain_valid), 32'h1);
    check("s2_slot0", 32'(drain_slot), 32'h0);
    check("s2_len0", 32'(drain_length), 32'd2);
    step(2'b00, 2'b00, 1'b1, 1'b0);
    check("s2_acc0", 32'(drain_valid), 32'h0);
    step(2'b00, 2'b00, 1'b1, 1'b0);
    step(2'b00, 2'b00, 1'b1, 1'b1);
    check("s2_empty0", 32'(fragment_slot_empty), 32'h1);
    check("s2_no_grant_yet", 32'(drain_valid), 32'h0);
    step(2'b00, 2'b00, 1'b1, 1'b0);
    check("s2_dv1", 32'(drain_valid), 32'h1);
    check("s2_slot1", 32'(drain_slot), 32'h1);
    step(2'b00, 2'b00, 1'b1, 1'b0);
    step(2'b00, 2'b00, 1'b1, 1'b0);
    step(2'b00, 2'b00, 1'b1, 1'b1);
    check("s2_empty_all", 32'(fragment_slot_empty), 32'h3);
    step(2'b11, 2'b00, 1'b0, 1'b0);
    step(2'b00, 2'b11, 1'b0, 1'b0);
    step(2'b00, 2'b00, 1'b0, 1'b0);
    check("s2_wrap_dv", 32'(drain_valid), 32'h1);
    check("s2_wrap_slot", 32'(drain_slot), 32'h0);
    check("s2_wrap_len", 32'(drain_length), 32'd1);

    // Inactivity timeout on slot 1
    do_reset();
    step(2'b10, 2'b00, 1'b0, 1'b0);
    check("s3_empty", 32'(fragment_slot_empty), 32'h1);
    seen = 1'b0;
    for (int n = 0; n < 7; n++) begin
      step(2'b00, 2'b00, 1'b0, 1'b0);
      seen = seen | (|slot_timeout);
    end
    check("s3_no_early_tmo", 32'(seen), 32'h0);
    step(2'b00, 2'b00, 1'b0, 1'b0);
    check("s3_tmo", 32'(slot_timeout), 32'h2);
    check("s3_empty_after", 32'(fragment_slot_empty), 32'h3);
    check("s3_id_cleared", fragment_slot_packet_id, 32'h0);
    step(2'b00, 2'b00, 1'b0, 1'b0);
    check("s3_tmo_pulse", 32'(slot_timeout), 32'h0);
    check("s3_no_dv", 32'(drain_valid), 32'h0);

    // Offer held with ready low while slot 1 completes
    do_reset();
    step(2'b01, 2'b00, 1'b0, 1'b0);
    step(2'b00, 2'b01, 1'b0, 1'b0);
    step(2'b00, 2'b00, 1'b0, 1'b0);
    check("s4_dv", 32'(drain_valid), 32'h1);
    step(2'b10, 2'b00, 1'b0, 1'b0);
    step(2'b10, 2'b00, 1'b0, 1'b0);
    step(2'b00, 2'b10, 1'b0, 1'b0);
    step(2'b00, 2'b00, 1'b0, 1'b0);
    step(2'b00, 2'b00, 1'b0, 1'b0);
    check("s4_hold_dv", 32'(drain_valid), 32'h1);
    check("s4_hold_slot", 32'(drain_slot), 32'h0);
    check("s4_hold_len", 32'(drain_length), 32'd1);
    step(2'b00, 2'b00, 1'b1, 1'b0);
    check("s4_acc", 32'(drain_valid), 32'h0);
    step(2'b00, 2'b00, 1'b0, 1'b0);
    check("s4_blocked", 32'(drain_valid), 32'h0);
    step(2'b00, 2'b00, 1'b0, 1'b1);
    check("s4_blocked_done", 32'(drain_valid), 32'h0);
    step(2'b00, 2'b00, 1'b0, 1'b0);
    check("s4_dv1", 32'(drain_valid), 32'h1);
    check("s4_slot1", 32'(drain_slot), 32'h1);
    check("s4_len1", 32'(drain_length), 32'd2);

    // Protocol errors
    do_reset();
    step(2'b01, 2'b00, 1'b0, 1'b0);
    step(2'b01, 2'b01, 1'b0, 1'b0);
    step(2'b01, 2'b00, 1'b0, 1'b1);
    check("s5_perr_push", 32'(protocol_error), 32'h1);
    check("s5_dv", 32'(drain_valid), 32'h1);
    check("s5_len", 32'(drain_length), 32'd2);
    step(2'b00, 2'b00, 1'b0, 1'b1);
    check("s5_done_ignored", 32'(protocol_error), 32'h0);
    check("s5_still_offered", 32'(drain_valid), 32'h1);
    check("s5_empty", 32'(fragment_slot_empty), 32'h2);
    step(2'b00, 2'b10, 1'b0, 1'b0);
    check("s5_perr_last_empty", 32'(protocol_error), 32'h1);
    check("s5_slot1_empty", 32'(fragment_slot_empty), 32'h2);

    // Overflow past MAX_PACKET_BYTES, then reset mid-FILLING
    do_reset();
    packet_id = 16'h0A0B;
    seen = 1'b0;
    for (int n = 0; n < 4; n++) begin
      step(2'b01, 2'b00, 1'b0, 1'b0);
      seen = seen | (|slot_timeout);
    end
    check("s6_no_early_ovf", 32'(seen), 32'h0);
    step(2'b01, 2'b00, 1'b0, 1'b0);
    check("s6_ovf_tmo", 32'(slot_timeout), 32'h1);
    check("s6_ovf_empty", 32'(fragment_slot_empty), 32'h3);
    step(2'b10, 2'b00, 1'b0, 1'b0);
    check("s6_fill1", 32'(fragment_slot_empty), 32'h1);
    check("s6_id1", 32'(fragment_slot_packet_id[31:16]), 32'h0A0B);
    reset_n = 1'b0;
    step(2'b00, 2'b00, 1'b0, 1'b0);
    check("s6_rst_empty", 32'(fragment_slot_empty), 32'h3);
    check("s6_rst_ids", fragment_slot_packet_id, 32'h0);
    check("s6_rst_tmo", 32'(slot_timeout), 32'h0);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 10; n++) begin
      step(2'b00, 2'b00, 1'b0, 1'b0);
      seen = seen | (|slot_timeout) | protocol_error | drain_valid;
    end
    check("s6_quiet_after_rst", 32'(seen), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/udp_fragment_slot_manager.md
Name: udp_fragment_slot_manager

Overview:
- Owns the FRAGMENT_SLOTS reassembly slots that the UDP receive handler pushes into.
- Tracks per-slot lifecycle EMPTY -> FILLING -> COMPLETE -> DRAINING -> EMPTY, and latches each slot's packet ID.
- Counts bytes per slot and retires stale slots on inactivity timeout.
- Round-robin arbitrates completed slots onto a single drain interface toward the UDP payload reader; feeds fragment_slot_empty and fragment_slot_packet_id back to the handler.

Parameters:
FRAGMENT_SLOTS, 2, number of reassembly slots (>=2)
TIMEOUT_CYCLES, 16'd1000, idle cycles allowed in FILLING before the slot is freed
MAX_PACKET_BYTES, 16'd1500, largest accepted reassembled payload in bytes

Ports:
clock  input  1  system clock
reset_n  input  1  synchronous active-low reset
push_data_valid  input  FRAGMENT_SLOTS  one-hot byte-push strobe per slot
push_data_last  input  FRAGMENT_SLOTS  one-hot last-fragment-complete strobe per slot
packet_id  input  16  IPv4 identification; stable whenever any push strobe is high
drain_ready  input  1  downstream accepts the offered slot
drain_done  input  1  downstream finished reading the slot in DRAINING
fragment_slot_empty  output  FRAGMENT_SLOTS  slot state is EMPTY
fragment_slot_packet_id  output  FRAGMENT_SLOTSx16  latched packet ID per slot
drain_valid  output  1  a COMPLETE slot is offered
drain_slot  output  clog2(FRAGMENT_SLOTS)  index of the offered slot
drain_length  output  16  byte count of the offered slot
slot_timeout  output  FRAGMENT_SLOTS  one-cycle pulse when a slot is freed by timeout or overflow
protocol_error  output  1  one-cycle pulse on a push or last into a non-accepting slot

Behaviour:
- Clocking: every register is updated on posedge clock.
- Reset: when reset_n=0 at a clock edge:
  - all slots EMPTY; fragment_slot_empty all 1s.
  - packet IDs, byte counts and idle counters 0.
  - drain_valid=0, drain_slot=0, drain_length=0, slot_timeout=0, protocol_error=0.
  - round-robin pointer 0.
  - Reset mid-operation discards all slot contents with no pulses.
- All outputs are registered. fragment_slot_empty reflects state with 1-cycle latency: a first push in cycle N gives empty=0 from N+1.
- EMPTY:
  - push_data_valid[i] -> state FILLING, latch packet_id, byte count=1, idle counter=0.
  - push_data_last[i] without a prior push -> protocol_error pulse; slot stays EMPTY.
- FILLING:
  - Each push_data_valid[i] increments the byte count and clears the idle counter.
  - A push with no strobe increments the idle counter.
  - push_data_last[i] -> COMPLETE. If valid and last are high in the same cycle, the byte is counted first.
  - Idle counter reaching TIMEOUT_CYCLES-1 with no push -> EMPTY, slot_timeout[i] pulse, ID and count cleared. If a push and timeout coincide, the push wins and the counter clears.
  - A byte count that would exceed MAX_PACKET_BYTES -> EMPTY, slot_timeout[i] pulse.
- COMPLETE: the slot is eligible for drain arbitration. A push or last strobe here -> protocol_error pulse; data is ignored.
- Arbitration:
  - Evaluated only when drain_valid=0 and no slot is DRAINING.
  - Scan starts at the round-robin pointer and wraps modulo FRAGMENT_SLOTS.
  - The first COMPLETE slot found: drain_valid=1 next cycle, with drain_slot=index and drain_length=byte count.
  - Pointer = index+1, wrapping FRAGMENT_SLOTS-1 -> 0.
- Drain handshake:
  - drain_valid, drain_slot and drain_length hold until drain_valid && drain_ready.
  - On that cycle the slot moves to DRAINING and drain_valid drops next cycle.
  - At most one slot is DRAINING at any time.
- DRAINING:
  - drain_done -> EMPTY; ID and count cleared.
  - The next grant comes no earlier than the cycle after the slot goes EMPTY.
  - drain_done while no slot is DRAINING is ignored.
  - A push into a DRAINING slot -> protocol_error pulse.
- Counters: byte count is 16 bits and checked before increment, so it never wraps. The idle counter is 16 bits and saturates.
- Multiple slots may change state in the same cycle. Each slot's transitions are independent apart from the single drain.

Test Plan:
- Reset, then push 3 bytes to slot 0 with packet_id=16'hBEEF, then last -> empty[0]=0 the cycle after the first push; fragment_slot_packet_id[0]=16'hBEEF; drain_valid=1, drain_slot=0, drain_length=3.
- Slots 0 and 1 complete in the same cycle, drain_ready held 1, drain_done 2 cycles after each accept -> grants slot 0 then slot 1; pointer wraps back to 0.
- TIMEOUT_CYCLES=8: push 1 byte to slot 1, then idle -> slot_timeout[1] pulses 8 cycles later; empty[1]=1; no drain_valid.
- drain_valid held with drain_ready=0 for 5 cycles while slot 1 completes -> drain_slot/drain_length stable; after accept, slot 1 is granted only after drain_done.
- Push to a COMPLETE slot, and drain_done with no DRAINING slot -> protocol_error pulses once for the push only; byte count is unchanged.
- MAX_PACKET_BYTES=4: push 5 bytes -> slot_timeout pulses on the 5th push; slot EMPTY; reset_n=0 mid-FILLING clears all state with no pulse.
